// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode map, ALUop encodings and state encoding shared by the multicycle control unit
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_SUBI  = 6'b000011;
    localparam logic [5:0] OP_ANDI  = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b000101;
    localparam logic [5:0] OP_SLTI  = 6'b000111;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b001001;
    localparam logic [5:0] OP_SW    = 6'b010000;
    localparam logic [5:0] OP_SB    = 6'b010001;
    localparam logic [5:0] OP_BEQ   = 6'b100011;
    localparam logic [5:0] OP_BNE   = 6'b100111;
    localparam logic [5:0] OP_MOVE  = 6'b100000;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JAL   = 6'b111001;

    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

endpackage

// File: rtl/mcu_perf_counters.sv
// rtl/mcu_perf_counters.sv - retired-instruction and memory-stall counters, wrapping modulo 2^CNT_W
module mcu_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_done,
    input  logic             stall,
    output logic [CNT_W-1:0] instr_retired,
    output logic [CNT_W-1:0] stall_cycles
);

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_retired <= '0;
            stall_cycles  <= '0;
        end else begin
            if (instr_done) instr_retired <= instr_retired + 1'b1;
            if (stall)      stall_cycles  <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - FETCH/DECODE/EXEC/MEM/WB control FSM with mem_ready stalls
// Optional perf counters enabled by defining MCU_PERF_CNT_EN.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pcWrite,
    output logic                pcWriteCond,
    output logic                irWrite,
    output logic                iorD,
    output logic                regDst,
    output logic                branch,
    output logic                memRead,
    output logic                memWrite,
    output logic                ALUsrc,
    output logic                regWrite,
    output logic                jump,
    output logic                byteOperations,
    output logic                move,
    output logic                memToReg,
    output logic [ALUOP_W-1:0]  ALUop,
    output logic                instr_done,
    output logic                illegal_op
`ifdef MCU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    instr_retired,
    output logic [CNT_W-1:0]    stall_cycles
`endif
);

    if (ALUOP_W < 3 || CNT_W < 1) begin : g_param_check
        $error("multicycle_control_unit: ALUOP_W must be >= 3 and CNT_W >= 1");
    end

    state_t              state, state_next;
    logic [OPCODE_W-1:0] op_q;
    logic [2:0]          alu;

    function automatic logic op_eq(input logic [OPCODE_W-1:0] op, input logic [5:0] code);
        return op == OPCODE_W'(code);
    endfunction

    logic is_rtype, is_alu_imm, is_load, is_store, is_byte, is_branch, is_move;
    logic is_j, is_jal, legal;
    logic [2:0] imm_alu;

    // Instruction class of the latched opcode; legal is the union of every class.
    always_comb begin
        is_rtype   = op_eq(op_q, OP_RTYPE);
        is_load    = op_eq(op_q, OP_LW) || op_eq(op_q, OP_LB);
        is_store   = op_eq(op_q, OP_SW) || op_eq(op_q, OP_SB);
        is_byte    = op_eq(op_q, OP_LB) || op_eq(op_q, OP_SB);
        is_branch  = op_eq(op_q, OP_BEQ) || op_eq(op_q, OP_BNE);
        is_move    = op_eq(op_q, OP_MOVE);
        is_j       = op_eq(op_q, OP_J);
        is_jal     = op_eq(op_q, OP_JAL);
        is_alu_imm = 1'b1;
        imm_alu    = ALU_ADD;
        if      (op_eq(op_q, OP_ADDI)) imm_alu = ALU_ADD;
        else if (op_eq(op_q, OP_SUBI)) imm_alu = ALU_SUB;
        else if (op_eq(op_q, OP_ANDI)) imm_alu = ALU_AND;
        else if (op_eq(op_q, OP_ORI))  imm_alu = ALU_OR;
        else if (op_eq(op_q, OP_SLTI)) imm_alu = ALU_SLT;
        else                           is_alu_imm = 1'b0;
        legal = is_rtype | is_alu_imm | is_load | is_store | is_branch | is_move | is_j | is_jal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            op_q       <= '0;
            illegal_op <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_FETCH && mem_ready) op_q <= opcode;
            if (state == S_DECODE && !legal)   illegal_op <= 1'b1;
        end
    end

    always_comb begin
        state_next     = state;
        pcWrite        = 1'b0;
        pcWriteCond    = 1'b0;
        irWrite        = 1'b0;
        iorD           = 1'b0;
        regDst         = 1'b0;
        branch         = 1'b0;
        memRead        = 1'b0;
        memWrite       = 1'b0;
        ALUsrc         = 1'b0;
        regWrite       = 1'b0;
        jump           = 1'b0;
        byteOperations = 1'b0;
        move           = 1'b0;
        memToReg       = 1'b0;
        instr_done     = 1'b0;
        alu            = ALU_FUNCT;
        case (state)
            S_FETCH: begin
                memRead = 1'b1;
                alu     = ALU_ADD;
                if (mem_ready) begin
                    irWrite    = 1'b1;
                    pcWrite    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_j || is_jal) begin
                    jump       = 1'b1;
                    pcWrite    = 1'b1;
                    regWrite   = is_jal;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end else if (!legal) begin
                    state_next = S_TRAP;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_rtype) begin
                    regDst     = 1'b1;
                    alu        = ALU_FUNCT;
                    state_next = S_WB;
                end else if (is_alu_imm) begin
                    ALUsrc     = 1'b1;
                    alu        = imm_alu;
                    state_next = S_WB;
                end else if (is_load || is_store) begin
                    ALUsrc         = 1'b1;
                    alu            = ALU_ADD;
                    byteOperations = is_byte;
                    state_next     = S_MEM;
                end else if (is_branch) begin
                    // Taken/not-taken and bne inversion are resolved in the datapath.
                    branch      = 1'b1;
                    pcWriteCond = 1'b1;
                    alu         = ALU_SUB;
                    instr_done  = 1'b1;
                    state_next  = S_FETCH;
                end else if (is_move) begin
                    move       = 1'b1;
                    alu        = ALU_ADD;
                    state_next = S_WB;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_MEM: begin
                iorD           = 1'b1;
                byteOperations = is_byte;
                if (is_load) begin
                    memRead = 1'b1;
                    if (mem_ready) state_next = S_WB;
                end else begin
                    memWrite = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end
            S_WB: begin
                regWrite   = 1'b1;
                memToReg   = is_load;
                regDst     = is_rtype;
                move       = is_move;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    assign ALUop = ALUOP_W'(alu);

`ifdef MCU_PERF_CNT_EN
    mcu_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk          (clk),
        .reset        (reset),
        .instr_done   (instr_done),
        .stall        ((state == S_FETCH || state == S_MEM) && !mem_ready),
        .instr_retired(instr_retired),
        .stall_cycles (stall_cycles)
    );
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic pcWrite, pcWriteCond, irWrite, iorD, regDst, branch, memRead, memWrite;
    logic ALUsrc, regWrite, jump, byteOperations, move, memToReg, instr_done, illegal_op;
    logic [2:0] ALUop;
`ifdef MCU_PERF_CNT_EN
    logic [31:0] instr_retired, stall_cycles;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [19:0] PCW = 20'h80000, PWC = 20'h40000, IRW = 20'h20000, IOD = 20'h10000;
    localparam logic [19:0] RDS = 20'h08000, BRA = 20'h04000, MRD = 20'h02000, MWR = 20'h01000;
    localparam logic [19:0] ASR = 20'h00800, RGW = 20'h00400, JMP = 20'h00200, BYT = 20'h00100;
    localparam logic [19:0] MOV = 20'h00080, MTR = 20'h00040, DON = 20'h00020, ILL = 20'h00010;
    localparam logic [19:0] A_ADD = 20'h1, A_SUB = 20'h2, A_AND = 20'h3, A_OR = 20'h4, A_SLT = 20'h5;

    multicycle_control_unit #(
        .OPCODE_W(6),
        .ALUOP_W (3),
        .CNT_W   (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pcWrite       (pcWrite),
        .pcWriteCond   (pcWriteCond),
        .irWrite       (irWrite),
        .iorD          (iorD),
        .regDst        (regDst),
        .branch        (branch),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .ALUsrc        (ALUsrc),
        .regWrite      (regWrite),
        .jump          (jump),
        .byteOperations(byteOperations),
        .move          (move),
        .memToReg      (memToReg),
        .ALUop         (ALUop),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op)
`ifdef MCU_PERF_CNT_EN
        ,
        .instr_retired (instr_retired),
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] ctl();
        return {pcWrite, pcWriteCond, irWrite, iorD, regDst, branch, memRead, memWrite,
                ALUsrc, regWrite, jump, byteOperations, move, memToReg, instr_done,
                illegal_op, 1'b0, ALUop};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Drive one cycle's inputs, check the control word, then advance a clock.
    task automatic cyc(input string tag, input logic [5:0] op, input logic mr, input logic [19:0] exp);
        opcode = op;
        mem_ready = mr;
        #1;
        check(tag, {12'h0, ctl()}, {12'h0, exp});
        tick();
    endtask

    logic [5:0]  imm_ops [5] = '{6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b000111};
    logic [19:0] imm_alu [5] = '{A_ADD, A_SUB, A_AND, A_OR, A_SLT};

    initial begin
        reset = 1'b1;
        opcode = '0;
        mem_ready = 1'b0;
        do_reset();

        // Reset state: stalled FETCH
        cyc("reset_fetch", 6'b000000, 1'b0, MRD | A_ADD);

        // R-type, zero-wait: 4 cycles
        do_reset();
        cyc("r_fetch",  6'b000000, 1'b1, MRD | IRW | PCW | A_ADD);
        cyc("r_decode", 6'b000000, 1'b1, 20'h0);
        cyc("r_exec",   6'b000000, 1'b1, RDS);
        cyc("r_wb",     6'b000000, 1'b1, RGW | RDS | DON);
        cyc("r_next",   6'b000000, 1'b0, MRD | A_ADD);

        // lw with three MEM wait cycles: 8 cycles
        do_reset();
        cyc("lw_fetch",  6'b001000, 1'b1, MRD | IRW | PCW | A_ADD);
        cyc("lw_decode", 6'b001000, 1'b1, 20'h0);
        cyc("lw_exec",   6'b001000, 1'b1, ASR | A_ADD);
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 6'b001000, 1'b0, MRD | IOD);
        cyc("lw_mem_ok", 6'b001000, 1'b1, MRD | IOD);
`ifdef MCU_PERF_CNT_EN
        check("lw_stall_cnt", stall_cycles, 32'd3);
`endif
        cyc("lw_wb",     6'b001000, 1'b1, RGW | MTR | DON);

        // sb, zero-wait: 4 cycles
        do_reset();
        cyc("sb_fetch",  6'b010001, 1'b1, MRD | IRW | PCW | A_ADD);
        cyc("sb_decode", 6'b010001, 1'b1, 20'h0);
        cyc("sb_exec",   6'b010001, 1'b1, ASR | BYT | A_ADD);
        cyc("sb_mem",    6'b010001, 1'b1, IOD | MWR | BYT | DON);
        cyc("sb_next",   6'b010001, 1'b0, MRD | A_ADD);

        // beq then jal back-to-back
        do_reset();
        cyc("beq_fetch",  6'b100011, 1'b1, MRD | IRW | PCW | A_ADD);
        cyc("beq_decode", 6'b100011, 1'b1, 20'h0);
        cyc("beq_exec",   6'b100011, 1'b1, BRA | PWC | DON | A_SUB);
        cyc("jal_fetch",  6'b111001, 1'b1, MRD | IRW | PCW | A_ADD);
        cyc("jal_decode", 6'b111001, 1'b1, JMP | PCW | RGW | DON);
`ifdef MCU_PERF_CNT_EN
        check("retired_2", instr_retired, 32'd2);
`endif
        cyc("jal_next",   6'b111001, 1'b0, MRD | A_ADD);

        // j: 2 cycles
        do_reset();
        cyc("j_fetch",  6'b111000, 1'b1, MRD | IRW | PCW | A_ADD);
        cyc("j_decode", 6'b111000, 1'b1, JMP | PCW | DON);

        // bne and move spot checks
        do_reset();
        cyc("bne_fetch",  6'b100111, 1'b1, MRD | IRW | PCW | A_ADD);
        cyc("bne_decode", 6'b100111, 1'b1, 20'h0);
        cyc("bne_exec",   6'b100111, 1'b1, BRA | PWC | DON | A_SUB);
        cyc("mv_fetch",   6'b100000, 1'b1, MRD | IRW | PCW | A_ADD);
        cyc("mv_decode",  6'b100000, 1'b1, 20'h0);
        cyc("mv_exec",    6'b100000, 1'b1, MOV | A_ADD);
        cyc("mv_wb",      6'b100000, 1'b1, RGW | MOV | DON);

        // Immediate ALU ops: EXEC ALUop per opcode
        for (int k = 0; k < 5; k++) begin
            do_reset();
            cyc("imm_fetch",  imm_ops[k], 1'b1, MRD | IRW | PCW | A_ADD);
            cyc("imm_decode", imm_ops[k], 1'b1, 20'h0);
            cyc("imm_exec",   imm_ops[k], 1'b1, ASR | imm_alu[k]);
            cyc("imm_wb",     imm_ops[k], 1'b1, RGW | DON);
        end

        // Illegal opcode: TRAP held 20 cycles regardless of mem_ready, cleared by reset
        do_reset();
        cyc("ill_fetch",  6'b111111, 1'b1, MRD | IRW | PCW | A_ADD);
        cyc("ill_decode", 6'b111111, 1'b1, 20'h0);
        for (int i = 0; i < 20; i++) cyc("ill_trap", 6'b000000, logic'(i[0]), ILL);
        do_reset();
        cyc("ill_cleared", 6'b000000, 1'b0, MRD | A_ADD);

        // Reset during stalled MEM of sw
        do_reset();
        cyc("sw_fetch",  6'b010000, 1'b1, MRD | IRW | PCW | A_ADD);
        cyc("sw_decode", 6'b010000, 1'b1, 20'h0);
        cyc("sw_exec",   6'b010000, 1'b1, ASR | A_ADD);
        cyc("sw_mem_wait", 6'b010000, 1'b0, IOD | MWR);
        opcode = 6'b010000;
        mem_ready = 1'b0;
        #1;
        check("sw_mem_hold", {12'h0, ctl()}, {12'h0, IOD | MWR});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("sw_after_reset", {12'h0, ctl()}, {12'h0, MRD | A_ADD});
`ifdef MCU_PERF_CNT_EN
        check("cnt_retired_rst", instr_retired, 32'd0);
        check("cnt_stall_rst", stall_cycles, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
